// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface pc_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            IMemReq;
    logic [XLEN-1:0] IMemAddr;
    logic            IMemAck;
    logic            IMemRspValid;
    logic [XLEN-1:0] IMemRspData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemRspValid,
        input  IMemRspData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemRspValid,
        output IMemRspData
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one memory read at a time,
// buffers one fetched instruction for IF/ID, and handles stall and redirect.
// Optional macro PC_ALIGN_CHECK_EN adds a FetchFault output and a sticky FAULT
// state entered on a misaligned redirect target.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Stall,
    input  logic                   Redirect,
    input  logic [31:0]            RedirectPC,
    pc_fetch_unit_if.master        imem,
    output logic                   InstrValid,
    output logic [31:0]            Instruction,
    output logic [31:0]            InstrPC,
`ifdef PC_ALIGN_CHECK_EN
    output logic [31:0]            PCPlus4,
    output logic                   FetchFault
`else
    output logic [31:0]            PCPlus4
`endif
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
`ifdef PC_ALIGN_CHECK_EN
        S_DROP  = 3'd3,
        S_FAULT = 3'd4
`else
        S_DROP  = 3'd3
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_inc;
    logic            r_req;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            w_capture;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] r_pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
    logic            r_fault;
    logic            w_fault_nxt;
    logic            w_misalign;
`endif

    assign w_pc_inc = r_pc + XLEN'(PC_STEP);

`ifdef PC_ALIGN_CHECK_EN
    assign w_misalign = Redirect && (RedirectPC[1:0] != 2'b00);
`endif

    // Next-state, next-PC and buffer-valid decode
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid && Stall;   // buffer drains when not stalled
        w_capture   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        w_fault_nxt = r_fault;
`endif
        case (r_state)
            S_IDLE: begin
                if (Redirect || !r_valid || !Stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (imem.IMemAck) begin
                    w_state_nxt = Redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.IMemRspValid) begin
                    w_state_nxt = Redirect ? S_REQ : S_IDLE;
                    w_capture   = !Redirect;
                end else if (Redirect) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem.IMemRspValid) begin
                    w_state_nxt = S_REQ;
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_capture) begin
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_inc;
        end

        // Redirect flushes the buffer and takes priority over the sequential PC
        if (Redirect
`ifdef PC_ALIGN_CHECK_EN
            && (r_state != S_FAULT)
`endif
           ) begin
            w_pc_nxt    = RedirectPC;
            w_valid_nxt = 1'b0;
        end

`ifdef PC_ALIGN_CHECK_EN
        // Misaligned target: park in FAULT; any late response is simply ignored there
        if (w_misalign && (r_state != S_FAULT)) begin
            w_state_nxt = S_FAULT;
            w_pc_nxt    = r_pc;
            w_valid_nxt = 1'b0;
            w_capture   = 1'b0;
            w_fault_nxt = 1'b1;
        end
`endif
    end

    // State, PC, request and output buffer registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_pc_plus4 <= '0;
`ifdef PC_ALIGN_CHECK_EN
            r_fault    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_req   <= (w_state_nxt == S_REQ);
            r_valid <= w_valid_nxt;
            if (w_capture) begin
                r_instr    <= imem.IMemRspData;
                r_instr_pc <= r_pc;
                r_pc_plus4 <= w_pc_inc;
            end
`ifdef PC_ALIGN_CHECK_EN
            r_fault <= w_fault_nxt;
`endif
        end
    end

    assign imem.IMemReq  = r_req;
    assign imem.IMemAddr = r_pc;
    assign InstrValid    = r_valid;
    assign Instruction   = r_instr;
    assign InstrPC       = r_instr_pc;
    assign PCPlus4       = r_pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
    assign FetchFault    = r_fault;
`endif

endmodule
